processor_debugger_cmd: RTL
===========================

Name: processor_debugger_cmd

Overview:
- Command-driven successor to the single-purpose register-dump debugger.
- Decodes a byte-stream command protocol from a UART receiver and issues the matching core debug requests: stop, go, single-step, read register, write register, full dump.
- Streams results back over a UART transmit byte interface.
- Sits between the UART byte module and the core debug port; register set and timeout are parametrised.

Parameters:
- P_GR_NUM, 32, number of general registers in a dump (targets 0..P_GR_NUM-1).
- P_SYS_NUM, 15, number of system registers in a dump (targets 64..64+P_SYS_NUM-1).
- P_TIMEOUT, 16'hFFFF, core-response timeout in cycles (used only with the optional feature).

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  asynchronous active-low reset.
- iRX_VALID  in  1  one-cycle strobe, received byte valid.
- iRX_DATA  in  8  received byte.
- oTX_REQ  out  1  transmit byte request.
- iTX_BUSY  in  1  transmitter busy.
- oTX_DATA  out  8  transmit byte.
- oDEBUG_CMD_REQ  out  1  core command request.
- iDEBUG_CMD_BUSY  in  1  core cannot accept a request.
- oDEBUG_CMD_COMMAND  out  4  0h read, 1h write, 8h go, Ah single-step, Fh stop.
- oDEBUG_CMD_TARGET  out  8  register target.
- oDEBUG_CMD_DATA  out  32  write data.
- iDEBUG_CMD_VALID  in  1  core response strobe.
- iDEBUG_CMD_ERROR  in  1  core response error, qualified by VALID.
- iDEBUG_CMD_DATA  in  32  read data.
- oRX_OVERRUN  out  1  sticky: a byte arrived while busy; cleared only by reset.

Behaviour:
- Reset: all outputs 0; state IDLE; argument counter, dump index and overrun flag cleared.
- Command bytes (ASCII):
  - 'S' (53h) stop.
  - 'G' (47h) go.
  - 'T' (54h) single-step.
  - 'r' (72h) read; 1 argument byte: target.
  - 'w' (77h) write; 5 argument bytes: target, then data MSB first.
  - 'D' (44h) dump all.
  - Any other byte in IDLE: send NAK 15h, return to IDLE.
- States: IDLE -> ARG (only if arguments are needed) -> REQ -> WAIT -> TX_STAT -> TX_DATA (read and dump only) -> IDLE.
- ARG: shift in bytes on iRX_VALID; the argument count is decided by the opcode.
- REQ:
  - oDEBUG_CMD_REQ is high while in REQ and !iDEBUG_CMD_BUSY.
  - COMMAND, TARGET and DATA are stable from REQ entry until the VALID response.
  - Handshake accepted in the same cycle; move to WAIT next cycle.
- WAIT:
  - On iDEBUG_CMD_VALID, latch iDEBUG_CMD_DATA and the error bit.
  - An error sets the status to NAK and skips data bytes.
- TX_STAT: send ACK 06h or NAK 15h.
- Byte send rule: oTX_REQ is a single-cycle pulse, issued only when !iTX_BUSY. The next byte waits until iTX_BUSY has been seen high, then low again.
- Read: ACK followed by 4 data bytes, MSB first.
- Dump:
  - Stop the core.
  - Loop over the targets: read, send 4 bytes, advance.
  - Order: GR 0..P_GR_NUM-1, then 64..64+P_SYS_NUM-1; the target jumps from P_GR_NUM-1 to 64.
  - After the last target, issue go, then send ACK.
  - Total bytes = 4*(P_GR_NUM+P_SYS_NUM)+1.
  - No register buffering: each word is streamed before the next read.
  - Any core error during a dump aborts it: go is still issued, then NAK is sent.
- Busy overrun: iRX_VALID outside IDLE/ARG drops the byte and sets oRX_OVERRUN.
- Simultaneous events: iRX_VALID in the same cycle as the return to IDLE is dropped.
- Reset mid-operation: immediate return to IDLE; partial transmissions are abandoned; the core is left in its current run state.
- Target width: index arithmetic is 8-bit. P_GR_NUM ≤ 64 and P_SYS_NUM ≤ 64, enforced by an elaboration-time check.

Optional Feature:
- Macro: PROCESSOR_DEBUGGER_CMD_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT and is cleared on entering REQ.
  - Reaching P_TIMEOUT forces NAK, drops oDEBUG_CMD_REQ and returns to IDLE. A dump in progress issues no go.
  - A late VALID arriving in IDLE is ignored.
- Undefined: WAIT waits indefinitely; no counter logic is present.

Decomposition:
- Shared package processor_debugger_pkg holds:
  - CORE_DEBUG_CMD_* command codes.
  - CORE_DEBUG_TARGET_* bases: GR0 = 0, CPUIDR = 64, PTIDR = 128.
  - ACK/NAK byte codes and the ASCII opcodes.
  - The state encoding.
- One natural sub-module: processor_debugger_cmd_txser, which serialises a 32-bit word or a single status byte onto the busy/req byte handshake and reports done.

Test Plan:
- 'r',03h; core returns 12345678h -> TX 06h,12h,34h,56h,78h; one REQ with command 0h, target 03h.
- 'w',05h,DEh,ADh,BEh,EFh -> one REQ with command 1h, target 05h, data DEADBEEFh; TX 06h.
- P_GR_NUM=4, P_SYS_NUM=2, 'D' -> requests in order:
  - stop (Fh);
  - reads 0,1,2,3,64,65;
  - go (8h).
  Expect TX of 25 bytes ending in 06h.
- 'r',07h; core responds with iDEBUG_CMD_ERROR=1 -> TX exactly 15h; back in IDLE.
- Byte 'X' -> TX 15h. Byte 'S' sent during a dump -> oRX_OVERRUN=1; dump completes unaffected.
- With PROCESSOR_DEBUGGER_CMD_TIMEOUT_EN and P_TIMEOUT=16, command 'S' and core silent -> TX 15h 16 cycles after request acceptance.

Source files
------------

// File: rtl/processor_debugger_pkg.sv
// Shared definitions for the command-driven processor debugger: core debug
// command codes, register target bases, protocol bytes, ASCII opcodes and the
// state encodings used by processor_debugger_cmd and its byte serialiser.
package processor_debugger_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned CMD_W  = 4;

   // Core debug port command codes
   localparam logic [CMD_W-1:0] CORE_DEBUG_CMD_READ        = 4'h0;
   localparam logic [CMD_W-1:0] CORE_DEBUG_CMD_WRITE       = 4'h1;
   localparam logic [CMD_W-1:0] CORE_DEBUG_CMD_GO          = 4'h8;
   localparam logic [CMD_W-1:0] CORE_DEBUG_CMD_SINGLE_STEP = 4'hA;
   localparam logic [CMD_W-1:0] CORE_DEBUG_CMD_STOP        = 4'hF;

   // Register target bases
   localparam logic [BYTE_W-1:0] CORE_DEBUG_TARGET_GR0    = 8'h00;
   localparam logic [BYTE_W-1:0] CORE_DEBUG_TARGET_CPUIDR = 8'h40;
   localparam logic [BYTE_W-1:0] CORE_DEBUG_TARGET_PTIDR  = 8'h80;

   // Status bytes returned to the host
   localparam logic [BYTE_W-1:0] DBG_ACK = 8'h06;
   localparam logic [BYTE_W-1:0] DBG_NAK = 8'h15;

   // ASCII command opcodes
   localparam logic [BYTE_W-1:0] OP_STOP  = 8'h53;  // 'S'
   localparam logic [BYTE_W-1:0] OP_GO    = 8'h47;  // 'G'
   localparam logic [BYTE_W-1:0] OP_STEP  = 8'h54;  // 'T'
   localparam logic [BYTE_W-1:0] OP_READ  = 8'h72;  // 'r'
   localparam logic [BYTE_W-1:0] OP_WRITE = 8'h77;  // 'w'
   localparam logic [BYTE_W-1:0] OP_DUMP  = 8'h44;  // 'D'

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARG,
      ST_REQ,
      ST_WAIT,
      ST_TX_STAT,
      ST_TX_DATA
   } dbg_state_e;

   typedef enum logic [1:0] {
      DUMP_STOP,
      DUMP_READ,
      DUMP_GO
   } dump_phase_e;

   typedef enum logic [1:0] {
      TXS_IDLE,
      TXS_SEND,
      TXS_WAIT_HI,
      TXS_WAIT_LO
   } txser_state_e;

   // Payload presented to the core debug port
   typedef struct packed {
      logic [CMD_W-1:0]  command;
      logic [BYTE_W-1:0] target;
      logic [WORD_W-1:0] data;
   } dbg_req_t;

   // Next dump target: general registers run up to gr_last, then system regs
   function automatic logic [BYTE_W-1:0] next_dump_target(
      input logic [BYTE_W-1:0] cur,
      input logic [BYTE_W-1:0] gr_last
   );
      return (cur == gr_last) ? CORE_DEBUG_TARGET_CPUIDR : BYTE_W'(cur + 8'd1);
   endfunction

endpackage

// File: rtl/processor_debugger_cmd_txser.sv
// Byte serialiser for the debugger's UART transmit side. On start_i it
// latches either a 32-bit word (4 bytes, MSB first) or a single byte taken
// from data_i[31:24], then sends each byte as a one-cycle tx_req_o pulse while
// the transmitter is idle, waiting for tx_busy_i to rise and fall again before
// the next byte. done_o pulses once after the last byte has been taken.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   start_i               begin a transfer (sampled when idle)
//   word_i                1: send 4 bytes, 0: send data_i[31:24] only
//   data_i[31:0]          payload
//   tx_busy_i             transmitter busy
//   tx_req_o, tx_data_o   byte request pulse and byte
//   done_o                transfer complete pulse
module processor_debugger_cmd_txser
   import processor_debugger_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              word_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              tx_busy_i,
   output logic              tx_req_o,
   output logic [BYTE_W-1:0] tx_data_o,
   output logic              done_o
);

   txser_state_e      state_q, state_d;
   logic [WORD_W-1:0] shr_q, shr_d;
   logic [1:0]        rem_q, rem_d;
   logic              req_q, req_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic              done_q, done_d;

   // Next-state: request, wait for busy high, wait for busy low, repeat
   always_comb begin
      state_d = state_q;
      shr_d   = shr_q;
      rem_d   = rem_q;
      req_d   = 1'b0;
      byte_d  = byte_q;
      done_d  = 1'b0;
      case (state_q)
         TXS_IDLE: begin
            if (start_i) begin
               shr_d   = data_i;
               rem_d   = word_i ? 2'd3 : 2'd0;
               state_d = TXS_SEND;
            end
         end
         TXS_SEND: begin
            if (!tx_busy_i) begin
               req_d   = 1'b1;
               byte_d  = shr_q[WORD_W-1 -: BYTE_W];
               state_d = TXS_WAIT_HI;
            end
         end
         TXS_WAIT_HI: begin
            if (tx_busy_i) state_d = TXS_WAIT_LO;
         end
         TXS_WAIT_LO: begin
            if (!tx_busy_i) begin
               if (rem_q == 2'd0) begin
                  done_d  = 1'b1;
                  state_d = TXS_IDLE;
               end else begin
                  shr_d   = {shr_q[WORD_W-BYTE_W-1:0], 8'h00};
                  rem_d   = rem_q - 2'd1;
                  state_d = TXS_SEND;
               end
            end
         end
         default: state_d = TXS_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= TXS_IDLE;
         shr_q   <= '0;
         rem_q   <= '0;
         req_q   <= 1'b0;
         byte_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shr_q   <= shr_d;
         rem_q   <= rem_d;
         req_q   <= req_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
      end
   end

   assign tx_req_o  = req_q;
   assign tx_data_o = byte_q;
   assign done_o    = done_q;

endmodule

// File: rtl/processor_debugger_cmd.sv
// Command-driven processor debugger. Decodes an ASCII byte-stream protocol
// from a UART receiver (S stop, G go, T step, r read, w write, D dump), issues
// the matching core debug requests and streams ACK/NAK plus read data back.
// Optional core-response timeout: define PROCESSOR_DEBUGGER_CMD_TIMEOUT_EN.
// Ports:
//   iCLOCK, inRESET            clock, asynchronous active-low reset
//   iRX_VALID, iRX_DATA        received byte strobe and byte
//   oTX_REQ, iTX_BUSY, oTX_DATA transmit byte handshake
//   oDEBUG_CMD_*               core debug request (REQ, COMMAND, TARGET, DATA)
//   iDEBUG_CMD_BUSY            core cannot accept a request
//   iDEBUG_CMD_VALID/ERROR/DATA core response
//   oRX_OVERRUN                sticky: a byte was dropped while busy
module processor_debugger_cmd
   import processor_debugger_pkg::*;
#(
   parameter int unsigned P_GR_NUM  = 32,
   parameter int unsigned P_SYS_NUM = 15,
   parameter logic [15:0] P_TIMEOUT = 16'hFFFF
) (
   input  logic              iCLOCK,
   input  logic              inRESET,
   input  logic              iRX_VALID,
   input  logic [BYTE_W-1:0] iRX_DATA,
   output logic              oTX_REQ,
   input  logic              iTX_BUSY,
   output logic [BYTE_W-1:0] oTX_DATA,
   output logic              oDEBUG_CMD_REQ,
   input  logic              iDEBUG_CMD_BUSY,
   output logic [CMD_W-1:0]  oDEBUG_CMD_COMMAND,
   output logic [BYTE_W-1:0] oDEBUG_CMD_TARGET,
   output logic [WORD_W-1:0] oDEBUG_CMD_DATA,
   input  logic              iDEBUG_CMD_VALID,
   input  logic              iDEBUG_CMD_ERROR,
   input  logic [WORD_W-1:0] iDEBUG_CMD_DATA,
   output logic              oRX_OVERRUN
);

   if (P_GR_NUM == 0 || P_GR_NUM > 64 || P_SYS_NUM > 64 || P_TIMEOUT == 16'd0) begin : g_param_err
      $error("processor_debugger_cmd: P_GR_NUM must be 1..64, P_SYS_NUM <= 64, P_TIMEOUT > 0");
   end

   localparam logic [BYTE_W-1:0] GR_LAST   = BYTE_W'(P_GR_NUM - 1);
   localparam logic [BYTE_W-1:0] SYS_LAST  = BYTE_W'(64 + P_SYS_NUM - 1);
   localparam logic [BYTE_W-1:0] DUMP_LAST = (P_SYS_NUM == 0) ? GR_LAST : SYS_LAST;

   dbg_state_e        state_q, state_d;
   dbg_req_t          req_q, req_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic [BYTE_W-1:0] stat_q, stat_d;
   logic [2:0]        need_q, need_d;
   logic [2:0]        argc_q, argc_d;
   logic              is_read_q, is_read_d;
   logic              dump_q, dump_d;
   dump_phase_e       phase_q, phase_d;
   logic              dump_err_q, dump_err_d;
   logic              tx_start_q, tx_start_d;
   logic              overrun_q, overrun_d;
   logic              tx_done;

`ifdef PROCESSOR_DEBUGGER_CMD_TIMEOUT_EN
   logic [15:0]       tmo_q, tmo_d;

   // Cycles spent waiting for the core; zero outside WAIT
   always_comb begin
      tmo_d = '0;
      if (state_q == ST_WAIT) tmo_d = tmo_q + 16'd1;
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) tmo_q <= '0;
      else          tmo_q <= tmo_d;
   end
`endif

   // Command decode, core handshake and response sequencing
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      rdata_d    = rdata_q;
      stat_d     = stat_q;
      need_d     = need_q;
      argc_d     = argc_q;
      is_read_d  = is_read_q;
      dump_d     = dump_q;
      phase_d    = phase_q;
      dump_err_d = dump_err_q;
      tx_start_d = 1'b0;
      overrun_d  = overrun_q;

      if (iRX_VALID && state_q != ST_IDLE && state_q != ST_ARG) overrun_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (iRX_VALID) begin
               is_read_d    = 1'b0;
               dump_d       = 1'b0;
               dump_err_d   = 1'b0;
               argc_d       = '0;
               req_d.target = '0;
               req_d.data   = '0;
               case (iRX_DATA)
                  OP_STOP: begin
                     req_d.command = CORE_DEBUG_CMD_STOP;
                     state_d       = ST_REQ;
                  end
                  OP_GO: begin
                     req_d.command = CORE_DEBUG_CMD_GO;
                     state_d       = ST_REQ;
                  end
                  OP_STEP: begin
                     req_d.command = CORE_DEBUG_CMD_SINGLE_STEP;
                     state_d       = ST_REQ;
                  end
                  OP_READ: begin
                     req_d.command = CORE_DEBUG_CMD_READ;
                     need_d        = 3'd1;
                     is_read_d     = 1'b1;
                     state_d       = ST_ARG;
                  end
                  OP_WRITE: begin
                     req_d.command = CORE_DEBUG_CMD_WRITE;
                     need_d        = 3'd5;
                     state_d       = ST_ARG;
                  end
                  OP_DUMP: begin
                     req_d.command = CORE_DEBUG_CMD_STOP;
                     dump_d        = 1'b1;
                     phase_d       = DUMP_STOP;
                     state_d       = ST_REQ;
                  end
                  default: begin
                     stat_d     = DBG_NAK;
                     tx_start_d = 1'b1;
                     state_d    = ST_TX_STAT;
                  end
               endcase
            end
         end
         ST_ARG: begin
            // First argument is the target, the rest shift in as data MSB first
            if (iRX_VALID) begin
               if (argc_q == 3'd0) req_d.target = iRX_DATA;
               else                req_d.data   = {req_q.data[WORD_W-BYTE_W-1:0], iRX_DATA};
               argc_d = argc_q + 3'd1;
               if (argc_q == need_q - 3'd1) state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!iDEBUG_CMD_BUSY) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (iDEBUG_CMD_VALID) begin
               rdata_d = iDEBUG_CMD_DATA;
               if (!dump_q) begin
                  stat_d     = iDEBUG_CMD_ERROR ? DBG_NAK : DBG_ACK;
                  tx_start_d = 1'b1;
                  state_d    = ST_TX_STAT;
               end else begin
                  case (phase_q)
                     DUMP_STOP, DUMP_READ: begin
                        if (iDEBUG_CMD_ERROR) begin
                           // Abort the dump but still let the core run again
                           dump_err_d    = 1'b1;
                           phase_d       = DUMP_GO;
                           req_d.command = CORE_DEBUG_CMD_GO;
                           state_d       = ST_REQ;
                        end else if (phase_q == DUMP_STOP) begin
                           phase_d       = DUMP_READ;
                           req_d.command = CORE_DEBUG_CMD_READ;
                           req_d.target  = CORE_DEBUG_TARGET_GR0;
                           state_d       = ST_REQ;
                        end else begin
                           tx_start_d = 1'b1;
                           state_d    = ST_TX_DATA;
                        end
                     end
                     default: begin
                        stat_d     = (dump_err_q || iDEBUG_CMD_ERROR) ? DBG_NAK : DBG_ACK;
                        tx_start_d = 1'b1;
                        state_d    = ST_TX_STAT;
                     end
                  endcase
               end
            end
`ifdef PROCESSOR_DEBUGGER_CMD_TIMEOUT_EN
            else if (tmo_q == P_TIMEOUT - 16'd1) begin
               // Silent core: report NAK, no go even inside a dump
               stat_d     = DBG_NAK;
               dump_d     = 1'b0;
               is_read_d  = 1'b0;
               tx_start_d = 1'b1;
               state_d    = ST_TX_STAT;
            end
`endif
         end
         ST_TX_STAT: begin
            if (tx_done) begin
               if (is_read_q && stat_q == DBG_ACK) begin
                  tx_start_d = 1'b1;
                  state_d    = ST_TX_DATA;
               end else begin
                  dump_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_TX_DATA: begin
            if (tx_done) begin
               if (!dump_q) begin
                  state_d = ST_IDLE;
               end else if (req_q.target == DUMP_LAST) begin
                  phase_d       = DUMP_GO;
                  req_d.command = CORE_DEBUG_CMD_GO;
                  state_d       = ST_REQ;
               end else begin
                  req_d.target = next_dump_target(req_q.target, GR_LAST);
                  state_d      = ST_REQ;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         rdata_q    <= '0;
         stat_q     <= '0;
         need_q     <= '0;
         argc_q     <= '0;
         is_read_q  <= 1'b0;
         dump_q     <= 1'b0;
         phase_q    <= DUMP_STOP;
         dump_err_q <= 1'b0;
         tx_start_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         rdata_q    <= rdata_d;
         stat_q     <= stat_d;
         need_q     <= need_d;
         argc_q     <= argc_d;
         is_read_q  <= is_read_d;
         dump_q     <= dump_d;
         phase_q    <= phase_d;
         dump_err_q <= dump_err_d;
         tx_start_q <= tx_start_d;
         overrun_q  <= overrun_d;
      end
   end

   processor_debugger_cmd_txser u_txser (
      .clk_i     (iCLOCK),
      .rst_ni    (inRESET),
      .start_i   (tx_start_q),
      .word_i    (state_q == ST_TX_DATA),
      .data_i    ((state_q == ST_TX_DATA) ? rdata_q : {stat_q, 24'h000000}),
      .tx_busy_i (iTX_BUSY),
      .tx_req_o  (oTX_REQ),
      .tx_data_o (oTX_DATA),
      .done_o    (tx_done)
   );

   // Request is offered only while the core can take it
   assign oDEBUG_CMD_REQ     = (state_q == ST_REQ) && !iDEBUG_CMD_BUSY;
   assign oDEBUG_CMD_COMMAND = req_q.command;
   assign oDEBUG_CMD_TARGET  = req_q.target;
   assign oDEBUG_CMD_DATA    = req_q.data;
   assign oRX_OVERRUN        = overrun_q;

endmodule
